fetch_sequencer: RTL and testbench

- Program-counter and fetch controller that drives the byte-addressed, big-endian, 1-cycle registered-read Instruction_memory (`clk`, `read_address` -> `instruction`).
- Generates sequential word addresses and absorbs memory latency, so a downstream stall never loses a fetched word.
- Handles branch/jump redirects with kill of in-flight fetches, and presents a valid/stall-handshaked instruction stream to decode.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_skid_buf.sv | 38 +++
 rtl/fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
// mips_pkg: shared widths, constants and the fetch entry record used by the
// fetch sequencer and its skid buffer.
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W     = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_WORD     = 32'h0000_0000;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] word;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Word-align an address and fold it into a power-of-two memory.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [ADDR_W-1:0] mask);
    return {addr[ADDR_W-1:2], 2'b00} & mask;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
`timescale 1ns/1ps
// fetch_skid_buf: single-entry (word, pc) holding register.
// Catches the word returning from memory while decode is stalled.
//   clk, rst_n : clock, async active-low reset
//   push       : capture din (entry becomes full)
//   pop        : release the entry (entry becomes empty)
//   flush      : discard the entry; wins over push and pop
//   din        : entry to capture
//   full       : entry holds a word
//   dout       : held entry
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output fetch_entry_t dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// fetch_sequencer: program counter and fetch control in front of a
// 1-cycle registered-read instruction memory. Issues sequential word
// fetches, parks a returning word in a skid entry when decode stalls,
// and kills in-flight work on a redirect.
//   clk, rst_n  : clock, async active-low reset
//   imem_addr   : memory read address (the pc register)
//   imem_instr  : memory data for the address presented last cycle
//   stall       : decode not ready, hold instr
//   redirect    : load redirect_pc as next fetch address
//   redirect_pc : branch/jump target
//   instr       : instruction word to decode
//   instr_pc    : address of instr
//   instr_valid : instr/instr_pc meaningful
//   align_err   : sticky, a redirect target was not word aligned
//   fetch_count : instructions accepted by decode
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int                IMEM_BYTES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               align_err,
  output logic [31:0]        fetch_count
);

  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(IMEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(WORD_BYTES);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_pc;
  logic              pend_v;

  logic              load;
  logic              accept;
  logic              skid_push;
  logic              skid_pop;
  logic              skid_full;
  logic              skid_full_next;
  logic              advance;
  fetch_entry_t      skid_q;
  fetch_entry_t      pend_entry;

  assign imem_addr  = pc;
  assign pend_entry = '{word: imem_instr, pc: pend_pc};

  // Output register is free to take a new word this edge.
  assign load   = !instr_valid || !stall;
  assign accept = instr_valid && !stall;

  // A word landing while the output is held goes to the skid. The skid is
  // never full while a word is in flight, because fetch stops whenever the
  // skid will be occupied.
  assign skid_push = !redirect && instr_valid && stall && pend_v;
  assign skid_pop  = !redirect && load && skid_full;

  always_comb begin
    skid_full_next = skid_full;
    if (redirect)       skid_full_next = 1'b0;
    else if (skid_push) skid_full_next = 1'b1;
    else if (skid_pop)  skid_full_next = 1'b0;
  end

  // Fetch only when an empty skid is guaranteed to exist next cycle, so the
  // word returning then always has a landing slot.
  assign advance = !redirect && !skid_full_next;

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (skid_push),
    .pop   (skid_pop),
    .flush (redirect),
    .din   (pend_entry),
    .full  (skid_full),
    .dout  (skid_q)
  );

  // pc / in-flight tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      pend_pc <= '0;
      pend_v  <= 1'b0;
    end else if (redirect) begin
      pc     <= wrap_addr(redirect_pc, PC_MASK);
      pend_v <= 1'b0;
    end else if (advance) begin
      pend_pc <= pc;
      pc      <= (pc + PC_STEP) & PC_MASK;
      pend_v  <= 1'b1;
    end else begin
      pend_v <= 1'b0;
    end
  end

  // Output register: skid has priority since it holds the older word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= NOP_WORD;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      if (skid_full) begin
        instr       <= skid_q.word;
        instr_pc    <= skid_q.pc;
        instr_valid <= 1'b1;
      end else if (pend_v) begin
        instr       <= imem_instr;
        instr_pc    <= pend_pc;
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  // Accepted-instruction counter and sticky alignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      align_err   <= 1'b0;
    end else begin
      if (accept)
        fetch_count <= fetch_count + 32'd1;
      if (redirect && (redirect_pc[1:0] != 2'b00))
        align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam int MEMB = 256;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        align_err;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  fetch_sequencer #(.RESET_PC(32'h0), .IMEM_BYTES(MEMB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .align_err   (align_err),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: two known words at 0 and 4, a tagged pattern elsewhere.
  function automatic logic [31:0] memval(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'd0)      w = 32'h014B_4822;
    else if (a == 32'd4) w = 32'h014B_6820;
    else                 w = 32'hC0DE_0000 | (a & 32'hFF);
    return w;
  endfunction

  // 1-cycle registered-read memory.
  initial imem_instr = '0;
  always @(posedge clk) imem_instr <= memval(imem_addr & (MEMB - 1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_addr();
    tests++;
    if (imem_addr > 32'(MEMB - 4) || imem_addr[1:0] != 2'b00) begin
      fails++;
      $display("FAIL imem_addr range: got %08h limit %08h", imem_addr, 32'(MEMB - 4));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] count;
    logic        align;
  } vec_t;

  vec_t vecs[24];

  task automatic setv(input int i, input logic s, input logic r, input logic [31:0] rp,
                      input logic v, input logic [31:0] p, input logic [31:0] c, input logic a);
    vecs[i] = '{stall: s, redirect: r, rpc: rp, valid: v, pc: p, count: c, align: a};
  endtask

  task automatic do_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model state for the random phase.
  logic [31:0] exp_next, m_count, held_pc, held_instr, tgt;
  logic        m_align, hold_prev;
  int          streak;

  initial begin
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    #2;
    // Reset state
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst instr_pc", instr_pc, 32'd0);
    chk("rst count", fetch_count, 32'd0);
    chk("rst align", 32'(align_err), 32'd0);
    chk("rst imem_addr", imem_addr, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Directed vectors: startup, 3-cycle stall, redirect over a full skid,
    // misaligned redirect, wrap at the top of memory.
    setv( 0, 0, 0, 0,     0, 0,     0, 0);
    setv( 1, 0, 0, 0,     0, 0,     0, 0);
    setv( 2, 0, 0, 0,     1, 0,     0, 0);
    setv( 3, 1, 0, 0,     1, 4,     1, 0);
    setv( 4, 1, 0, 0,     1, 4,     1, 0);
    setv( 5, 1, 0, 0,     1, 4,     1, 0);
    setv( 6, 0, 0, 0,     1, 4,     1, 0);
    setv( 7, 0, 0, 0,     1, 8,     2, 0);
    setv( 8, 0, 0, 0,     1, 12,    3, 0);
    setv( 9, 1, 0, 0,     1, 16,    4, 0);
    setv(10, 1, 1, 'h40,  1, 16,    4, 0);
    setv(11, 0, 0, 0,     0, 0,     4, 0);
    setv(12, 0, 0, 0,     0, 0,     4, 0);
    setv(13, 0, 0, 0,     1, 'h40,  4, 0);
    setv(14, 0, 1, 'h43,  1, 'h44,  5, 0);
    setv(15, 0, 0, 0,     0, 0,     6, 1);
    setv(16, 0, 0, 0,     0, 0,     6, 1);
    setv(17, 0, 1, 'hF8,  1, 'h40,  6, 1);
    setv(18, 0, 0, 0,     0, 0,     7, 1);
    setv(19, 0, 0, 0,     0, 0,     7, 1);
    setv(20, 0, 0, 0,     1, 'hF8,  7, 1);
    setv(21, 0, 0, 0,     1, 'hFC,  8, 1);
    setv(22, 0, 0, 0,     1, 0,     9, 1);
    setv(23, 0, 0, 0,     1, 4,    10, 1);

    for (int i = 0; i < 24; i++) begin
      stall = vecs[i].stall;
      redirect = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d valid", i), 32'(instr_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].pc);
        chk($sformatf("v%0d instr", i), instr, memval(vecs[i].pc));
      end
      chk($sformatf("v%0d count", i), fetch_count, vecs[i].count);
      chk($sformatf("v%0d align", i), 32'(align_err), 32'(vecs[i].align));
      chk_addr();
      @(posedge clk);
      #1;
    end
    redirect = 1'b0;

    // Reset asserted mid-stall with the skid full.
    stall = 1'b1;
    tick(); tick(); tick();
    chk("pre-reset valid", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(instr_valid), 32'd0);
    chk("mid rst instr", instr, 32'd0);
    chk("mid rst instr_pc", instr_pc, 32'd0);
    chk("mid rst count", fetch_count, 32'd0);
    chk("mid rst align", 32'(align_err), 32'd0);
    chk("mid rst imem_addr", imem_addr, 32'd0);
    tick();
    stall = 1'b0;
    rst_n = 1'b1;
    chk("post rst c0 valid", 32'(instr_valid), 32'd0);
    tick();
    chk("post rst c1 valid", 32'(instr_valid), 32'd0);
    tick();
    chk("post rst c2 valid", 32'(instr_valid), 32'd1);
    chk("post rst c2 pc", instr_pc, 32'd0);
    chk("post rst c2 instr", instr, 32'h014B_4822);
    chk("post rst c2 count", fetch_count, 32'd0);
    tick();
    chk("post rst c3 pc", instr_pc, 32'd4);
    chk("post rst c3 instr", instr, 32'h014B_6820);
    chk("post rst c3 count", fetch_count, 32'd1);

    // Random phase against a stream-level model: decode must see the
    // address sequence start, start+4, ... (mod memory size), restarting at
    // each redirect target, with nothing lost, duplicated or reordered.
    do_reset();
    exp_next = 0; m_count = 0; m_align = 0; hold_prev = 0; streak = 0;
    held_pc = 0; held_instr = 0;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      #1;
      chk_addr();
      chk("rnd count", fetch_count, m_count);
      chk("rnd align", 32'(align_err), 32'(m_align));
      if (hold_prev) begin
        chk("rnd hold valid", 32'(instr_valid), 32'd1);
        chk("rnd hold pc", instr_pc, held_pc);
        chk("rnd hold instr", instr, held_instr);
      end
      if (!instr_valid) begin
        streak++;
        if (streak > 2) begin
          tests++; fails++;
          $display("FAIL rnd starve: got %0d idle cycles allowed 2", streak);
        end
      end else begin
        streak = 0;
      end
      if (instr_valid && !stall) begin
        chk("rnd seq pc", instr_pc, exp_next);
        chk("rnd seq instr", instr, memval(exp_next));
        exp_next = (exp_next + 4) % MEMB;
        m_count++;
      end
      hold_prev = instr_valid && stall && !redirect;
      held_pc = instr_pc;
      held_instr = instr;
      if (redirect) begin
        tgt = redirect_pc - (redirect_pc % 4);
        exp_next = tgt % MEMB;
        if (redirect_pc % 4 != 0) m_align = 1'b1;
        streak = 0;
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
